// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
//
// Contents: op codes, FSM state encoding, step-datapath mode, counter width.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } step_mode_t;

  // Iteration counter width: wide enough to hold WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath (shift-add or restoring step).
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the outputs.
//
// Ports:
//   mode    MODE_MUL: acc_hi += acc_lo[0] ? opnd : 0, then {acc_hi,acc_lo} >>= 1
//           MODE_DIV: shift {acc_hi,acc_lo} left, trial-subtract opnd from the
//                     upper half, shift the quotient bit into acc_lo
//   acc_hi  upper accumulator half (product high / partial remainder)
//   acc_lo  lower accumulator half (multiplier / dividend -> quotient)
//   opnd    multiplicand or divisor magnitude
//   nxt_hi, nxt_lo  accumulator after the step
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  step_mode_t       mode,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  always_comb begin
    // Multiply: add, keep the carry, shift the whole accumulator right.
    sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

    // Divide: the shifted partial remainder needs WIDTH+1 bits. When the
    // subtraction succeeds the difference is below the divisor, so the low
    // WIDTH bits hold it exactly.
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    borrow  = shifted < {1'b0, opnd};
    diff    = shifted[WIDTH-1:0] - opnd;

    nxt_hi = acc_hi;
    nxt_lo = acc_lo;
    if (mode == MODE_MUL) begin
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end else begin
      nxt_hi = borrow ? shifted[WIDTH-1:0] : diff;
      nxt_lo = {acc_lo[WIDTH-2:0], ~borrow};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; MTHI/MTLO write directly.
// Latency: mul/div result and done at WIDTH+1 edges after acceptance; MTHI/MTLO 1 edge.
// Backpressure: busy high in CALC/FIX; start ignored (not queued) unless IDLE/DONE.
//
// Ports: clk, rst (sync, active high), start, op[2:0], op_a, op_b,
//        busy, done (1-cycle pulse), hi, lo.
// Build option: MULDIV_SIGNED_EN enables signed MULT/DIV; without it MULT and
// DIV behave as MULTU and DIVU with unchanged latency.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q, div0_q;
  logic [WIDTH-1:0] a_raw_q, opnd_q, acc_hi_q, acc_lo_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             ready, load, step_en, fix_en, mt_wr;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem, res_hi, res_lo;

`ifdef MULDIV_SIGNED_EN
  logic signed_op, a_neg, b_neg;
  logic neg_res_q, neg_rem_q;
`endif

  assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign mt_wr = ready && start && ((op == OP_MTHI) || (op == OP_MTLO));

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    load    = 1'b0;
    step_en = 1'b0;
    fix_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // op[2]==0 selects the four mul/div codes.
        if (start && !op[2]) begin
          state_d = ST_CALC;
          load    = 1'b1;
        end
      end
      ST_CALC: begin
        busy    = 1'b1;
        step_en = 1'b1;
        if (cnt_q == LAST) state_d = ST_FIX;
      end
      ST_FIX: begin
        busy    = 1'b1;
        fix_en  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start && !op[2]) begin
          state_d = ST_CALC;
          load    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- operand magnitudes ----------------
  always_comb begin
    a_mag = op_a;
    b_mag = op_b;
`ifdef MULDIV_SIGNED_EN
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = signed_op && op_a[WIDTH-1];
    b_neg     = signed_op && op_b[WIDTH-1];
    if (a_neg) a_mag = -op_a;
    if (b_neg) b_mag = -op_b;
`endif
  end

  // ---------------- iteration step ----------------
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode   (is_div_q ? MODE_DIV : MODE_MUL),
    .acc_hi (acc_hi_q),
    .acc_lo (acc_lo_q),
    .opnd   (opnd_q),
    .nxt_hi (nxt_hi),
    .nxt_lo (nxt_lo)
  );

  // ---------------- result correction ----------------
  always_comb begin
    prod = {acc_hi_q, acc_lo_q};
    quo  = acc_lo_q;
    rem  = acc_hi_q;
`ifdef MULDIV_SIGNED_EN
    if (neg_res_q) begin
      prod = -prod;
      quo  = -quo;
    end
    // Remainder follows the dividend's sign.
    if (neg_rem_q) rem = -rem;
`endif
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div_q) begin
      if (div0_q) begin
        res_hi = a_raw_q;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      div0_q    <= 1'b0;
      a_raw_q   <= '0;
      opnd_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      if (load) begin
        cnt_q     <= '0;
        is_div_q  <= op[1];
        div0_q    <= op[1] && (op_b == '0);
        a_raw_q   <= op_a;
        // Multiply adds op_a while shifting out op_b; divide shifts op_a
        // (dividend) through against op_b (divisor).
        opnd_q    <= op[1] ? b_mag : a_mag;
        acc_hi_q  <= '0;
        acc_lo_q  <= op[1] ? a_mag : b_mag;
`ifdef MULDIV_SIGNED_EN
        neg_res_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
`endif
      end else if (step_en) begin
        cnt_q    <= cnt_q + CW'(1);
        acc_hi_q <= nxt_hi;
        acc_lo_q <= nxt_lo;
      end

      if (fix_en) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (mt_wr) begin
        if (op == OP_MTHI) hi_q <= op_a;
        else               lo_q <= op_a;
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv (WIDTH=32): results, timing, ignored and
// back-to-back starts, mid-op reset, MTHI/MTLO and reserved ops.
module tb_ex_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] op_a, op_b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  ex_muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .op_a  (op_a),
    .op_b  (op_b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op    = o;
    op_a  = a;
    op_b  = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs to show operands were latched.
    op    = 3'd7;
    op_a  = $urandom;
    op_b  = $urandom;
  endtask

  // Full op with timing checks; returns at the negedge in the DONE cycle.
  task automatic run_chk(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                         input logic [W-1:0] exp_lo);
    int bc;
    int dn;
    bc = 0;
    dn = 0;
    issue(o, a, b);
    for (int k = 0; k <= W; k++) begin
      if (k > 0) @(negedge clk);
      bc += int'(busy);
      dn += int'(done);
    end
    chk({tag, "_busy_cycles"}, 64'(bc), 64'(W + 1));
    chk({tag, "_early_done"}, 64'(dn), 64'd0);
    @(negedge clk);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy_in_done"}, 64'(busy), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    int dn;
    rst   = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);

    // ---- results ----
    run_chk("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    @(negedge clk);
    chk("idle_after_done", 64'(done), 64'd0);
`ifdef MULDIV_SIGNED_EN
    run_chk("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_chk("div_neg", 3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_chk("div_negb", 3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_chk("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
`else
    run_chk("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'h0000_0004, 32'hFFFF_FFF1);
    run_chk("div_neg", 3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC);
    run_chk("div_negb", 3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0007, 32'h0000_0000);
    run_chk("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);
`endif
    run_chk("divu_7_2", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3);
    run_chk("divu_by0", 3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    @(negedge clk);

    // ---- start during CALC is ignored ----
    issue(3'd1, 32'd3, 32'd4);            // after edge N
    @(negedge clk);                        // after N+1
    @(negedge clk);                        // after N+2
    start = 1'b1;
    op    = 3'd3;
    op_a  = 32'd100;
    op_b  = 32'd7;
    @(negedge clk);                        // sampled at N+3
    start = 1'b0;
    dn = 0;
    for (int k = 0; k < 45; k++) begin
      dn += int'(done);
      @(negedge clk);
    end
    chk("ignored_start_dones", 64'(dn), 64'd1);
    chk("ignored_start_hi", 64'(hi), 64'd0);
    chk("ignored_start_lo", 64'(lo), 64'd12);

    // ---- back-to-back: second start in the DONE cycle ----
    run_chk("b2b_first", 3'd1, 32'd6, 32'd7, 32'd0, 32'd42);
    issue(3'd3, 32'd100, 32'd7);           // accepted at the DONE edge
    chk("b2b_busy_after_accept", 64'(busy), 64'd1);
    chk("b2b_done_after_accept", 64'(done), 64'd0);
    dn = 0;
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      dn += int'(done);
    end
    chk("b2b_early_done", 64'(dn), 64'd0);
    @(negedge clk);
    chk("b2b_second_done", 64'(done), 64'd1);
    chk("b2b_second_hi", 64'(hi), 64'd2);
    chk("b2b_second_lo", 64'(lo), 64'd14);
    @(negedge clk);

    // ---- reset mid-CALC ----
    issue(3'd3, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      dn += int'(done) + int'(busy);
      @(negedge clk);
    end
    chk("midrst_no_done", 64'(dn), 64'd0);

    // ---- MTHI / MTLO / reserved ----
    issue(3'd4, 32'h0000_1234, 32'd0);
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_lo", 64'(lo), 64'd0);
    chk("mthi_busy", 64'(busy), 64'd0);
    chk("mthi_done", 64'(done), 64'd0);
    issue(3'd5, 32'hCAFE_F00D, 32'd0);
    chk("mtlo_lo", 64'(lo), 64'hCAFE_F00D);
    chk("mtlo_hi", 64'(hi), 64'h1234);
    issue(3'd6, 32'hDEAD_BEEF, 32'd1);
    @(negedge clk);
    chk("rsvd_busy", 64'(busy), 64'd0);
    chk("rsvd_hilo", {hi, lo}, {32'h0000_1234, 32'hCAFE_F00D});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit for the execute stage, owning the architectural HI/LO registers. It accepts one MULT/MULTU/DIV/DIVU operation at a time from the decode/execute control, computes it over WIDTH cycles with a shift-add multiplier or a restoring divider, and writes the 2·WIDTH-bit result into HI/LO. MTHI/MTLO are single-cycle writes. It sits beside the ALU and shifter; the pipeline stalls on `busy`.

## Interface
- WIDTH, 32: operand and HI/LO width; must be ≥ 4.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when ready, i.e. state IDLE or DONE.
- op  in  3  operation code: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6 and 7 are reserved and ignored.
- op_a  in  WIDTH  multiplicand, dividend, or MTHI/MTLO data.
- op_b  in  WIDTH  multiplier or divisor.
- busy  out  1  high in CALC and FIX.
- done  out  1  one-cycle pulse in DONE.
- hi  out  WIDTH  HI register; remainder, or upper product half.
- lo  out  WIDTH  LO register; quotient, or lower product half.

## Operation
- FSM states:
  - IDLE: on start with op 0–3, go to CALC. On start with MTHI/MTLO, write hi or lo from op_a and stay in IDLE. On reserved op, stay in IDLE.
  - CALC: iterates WIDTH times under a counter; on the last iteration go to FIX.
  - FIX: applies sign correction and special cases, writes hi/lo, goes to DONE.
  - DONE: start is accepted exactly as in IDLE; otherwise go to IDLE.
- op, op_a and op_b are latched at acceptance. Later input changes have no effect.
- start in CALC or FIX is ignored; it is not queued.
- Multiply: 2·WIDTH accumulator, one multiplier bit per cycle.
- Divide: restoring, one quotient bit per cycle; the partial remainder is WIDTH+1 bits.
- Signed ops (MULT, DIV):
  - Operands are converted to magnitudes before iteration.
  - The product is negated (2·WIDTH-bit negate) if the operand signs differ.
  - The quotient is negated if the signs differ; the remainder takes the dividend's sign.
  - DIV of the most-negative value by −1 gives lo = most-negative, hi = 0, with no special casing.
- Divide by zero (DIV or DIVU): lo = all ones, hi = latched op_a. Forced in FIX; no exception.
- hi/lo change only in FIX, on an MTHI/MTLO write, or on reset.

## Timing
- Reset values: state IDLE, busy 0, done 0, hi 0, lo 0, counter 0.
- Start accepted at edge N:
  - busy is high from edge N to edge N+WIDTH+1.
  - hi/lo hold the result from edge N+WIDTH+1.
  - done is high from edge N+WIDTH+1 to N+WIDTH+2, and busy is 0 in that cycle.
- Latency is identical for every op and every data value; there is no early termination.
- Back-to-back: a start in DONE is accepted at that edge. The next op's done arrives WIDTH+1 edges later, with no idle cycle.
- MTHI/MTLO: value visible one edge after acceptance; busy and done stay 0.
- rst high at any edge, including mid-CALC: the next state is the reset state. The in-flight op is discarded, no done is issued, and hi/lo are cleared.

## Configuration
- MULDIV_SIGNED_EN defined: MULT and DIV are signed as described above.
- MULDIV_SIGNED_EN undefined:
  - MULT executes as MULTU and DIV executes as DIVU.
  - The magnitude and negate logic is removed.
  - FIX is still traversed, so latency is unchanged.

## Structure
- Package `muldiv_pkg`: op code constants, state encoding (IDLE, CALC, FIX, DONE), and the counter width $clog2(WIDTH+1).
- Sub-module `muldiv_step`: combinational single-iteration datapath for one shift-add or one restoring subtract/compare step, selected by a mode input. It is instantiated once in `ex_muldiv`, which keeps the FSM, counter, operand latches and HI/LO.

## Test plan
All scenarios use WIDTH=32 with MULDIV_SIGNED_EN defined unless stated.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, start at edge N → hi=0xFFFFFFFE, lo=0x00000001; done high only after edge N+33; busy high for 33 cycles.
- MULT 0xFFFFFFFD × 0x00000005 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Without the macro → hi=0x00000004, lo=0xFFFFFFF1.
- DIV 0xFFFFFFF9 ÷ 0x00000002 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 ÷ 2 → lo=3, hi=1.
- DIVU 5 ÷ 0 → lo=0xFFFFFFFF, hi=5. DIV 0x80000000 ÷ 0xFFFFFFFF → lo=0x80000000, hi=0.
- Second start 3 cycles after the first → ignored; exactly one done; result is from the first op. A start in the DONE cycle → second done follows 33 edges later.
- rst at cycle 10 of a DIVU → busy=0, hi=lo=0, no done pulse. Then MTHI 0x1234 → hi=0x1234 one edge later, with busy and done staying 0.
